// File: rtl/subgroup_pkg.sv
// Shared types and constants for the subgroup dispatcher and its credit counters.
package subgroup_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Wide enough for MAX_OUT up to 15.
  localparam int CNT_W = 4;
endpackage

// File: rtl/subgroup_credit_cnt.sv
// Outstanding-item counter for one child; flags a completion with nothing outstanding.
module subgroup_credit_cnt
  import subgroup_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             under_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count; a simultaneous dispatch and completion cancel out.
  always_comb begin
    cnt_d   = cnt_q;
    under_o = 1'b0;
    case ({inc_i, dec_i})
      2'b10: cnt_d = cnt_q + CNT_W'(1);
      2'b01: begin
        if (cnt_q == CNT_W'(0)) begin
          under_o = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_W'(0);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/subgroup_dispatcher.sv
// Round-robin dispatcher: one holding register feeding NUM_CHILD children, with
// per-child credit limits and a flush/drain handshake.
module subgroup_dispatcher
  import subgroup_pkg::*;
#(
  parameter int NUM_CHILD = 5,
  parameter int DATA_W    = 8,
  parameter int MAX_OUT   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_W-1:0]    s_data,
  output logic [NUM_CHILD-1:0] m_valid,
  input  logic [NUM_CHILD-1:0] m_ready,
  output logic [DATA_W-1:0]    m_data,
  input  logic [NUM_CHILD-1:0] done,
  input  logic                 flush,
  output logic                 flush_done,
  output logic                 busy,
  output logic                 err_underflow
);

  localparam int PTR_W = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1;

  state_e              state_q, state_d;
  logic                hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0]   hold_data_q, hold_data_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                err_q, err_d;
  logic [NUM_CHILD-1:0] elig_s, grant_s, under_s, cnt_nz_s;
  logic [CNT_W-1:0]    cnt_s [NUM_CHILD];
  logic [PTR_W-1:0]    grant_idx_s;
  logic                found_s, hit_s, dispatch_s, accept_s, ready_s, drain_empty_s;
  int                  idx_v;

  for (genvar i = 0; i < NUM_CHILD; i++) begin : g_child
    assign elig_s[i]   = hold_valid_q && m_ready[i] && (cnt_s[i] < CNT_W'(MAX_OUT));
    assign cnt_nz_s[i] = |cnt_s[i];

    subgroup_credit_cnt u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (grant_s[i]),
      .dec_i   (done[i]),
      .cnt_o   (cnt_s[i]),
      .under_o (under_s[i])
    );
  end

  // Round-robin search starting at rr_ptr; the first eligible child wins.
  always_comb begin
    grant_s     = '0;
    grant_idx_s = '0;
    found_s     = 1'b0;
    hit_s       = 1'b0;
    idx_v       = 0;
    for (int j = 0; j < NUM_CHILD; j++) begin
      idx_v          = (int'(rr_ptr_q) + j) % NUM_CHILD;
      hit_s          = !found_s && elig_s[idx_v];
      grant_s[idx_v] = grant_s[idx_v] | hit_s;
      grant_idx_s    = hit_s ? PTR_W'(idx_v) : grant_idx_s;
      found_s        = found_s | hit_s;
    end
  end

  assign dispatch_s    = |grant_s;
  assign ready_s       = (state_q == RUN) && (!hold_valid_q || dispatch_s);
  assign accept_s      = s_valid && ready_s;
  assign drain_empty_s = !hold_valid_q && !(|cnt_nz_s);

  // Next state for FSM, holding register, pointer and sticky error.
  always_comb begin
    state_d      = state_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    rr_ptr_d     = rr_ptr_q;
    err_d        = err_q | (|under_s);

    if (accept_s) begin
      hold_valid_d = 1'b1;
      hold_data_d  = s_data;
    end else if (dispatch_s) begin
      hold_valid_d = 1'b0;
    end else begin
      hold_valid_d = hold_valid_q;
    end

    if (dispatch_s) begin
      rr_ptr_d = (grant_idx_s == PTR_W'(NUM_CHILD - 1)) ? PTR_W'(0) : grant_idx_s + PTR_W'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end

    case (state_q)
      IDLE:    state_d = flush ? IDLE : RUN;
      RUN:     state_d = flush ? DRAIN : RUN;
      DRAIN:   state_d = drain_empty_s ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      rr_ptr_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      rr_ptr_q     <= rr_ptr_d;
      err_q        <= err_d;
    end
  end

  assign s_ready       = ready_s;
  assign m_valid       = grant_s;
  assign m_data        = hold_data_q;
  assign flush_done    = (state_q == DRAIN) && drain_empty_s;
  assign busy          = hold_valid_q || (|cnt_nz_s);
  assign err_underflow = err_q;

endmodule

// File: tb/tb_subgroup_dispatcher.sv
// Directed bench for subgroup_dispatcher with hand-computed expectations.
module tb_subgroup_dispatcher;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid, s_ready, flush, flush_done, busy, err_underflow;
  logic [7:0] s_data, m_data;
  logic [4:0] m_valid, m_ready, done;

  int n_checks = 0;
  int n_errors = 0;

  subgroup_dispatcher #(.NUM_CHILD(5), .DATA_W(8), .MAX_OUT(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .done          (done),
    .flush         (flush),
    .flush_done    (flush_done),
    .busy          (busy),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One cycle: drive at the falling edge, settle, then the caller checks.
  task automatic cyc(input logic sv, input logic [7:0] sd, input logic [4:0] mr,
                     input logic [4:0] dn, input logic fl);
    @(negedge clk);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    done    = dn;
    flush   = fl;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_ready = 5'b0; done = 5'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_s_ready", s_ready, 1'b0);
    check_val("rst_m_valid", m_valid, 5'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_flush_done", flush_done, 1'b0);
    check_val("rst_err", err_underflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("idle_s_ready", s_ready, 1'b0);

    // Five items back-to-back, all children ready: children 0..4 in order.
    for (int k = 0; k < 6; k++) begin
      cyc(k < 5, 8'hA0 + 8'(k), 5'b11111, 5'b0, 1'b0);
      if (k < 5) check_val("a_s_ready", s_ready, 1'b1);
      if (k >= 1) begin
        check_val("a_m_valid", m_valid, 5'b00001 << (k - 1));
        check_val("a_m_data", m_data, 8'hA0 + 8'(k - 1));
      end
    end
    cyc(1'b0, 8'h00, 5'b11111, 5'b0, 1'b0);
    check_val("a_idle_m_valid", m_valid, 5'b0);
    check_val("a_busy", busy, 1'b1);
    cyc(1'b0, 8'h00, 5'b0, 5'b11111, 1'b0);
    cyc(1'b0, 8'h00, 5'b0, 5'b0, 1'b0);
    check_val("a_clear_busy", busy, 1'b0);
    check_val("a_clear_err", err_underflow, 1'b0);

    // Sparse ready 10100 from pointer 0, then wrap back to child 0.
    cyc(1'b1, 8'hB0, 5'b10100, 5'b0, 1'b0);
    cyc(1'b1, 8'hB1, 5'b10100, 5'b0, 1'b0);
    check_val("b_first", m_valid, 5'b00100);
    cyc(1'b1, 8'hB2, 5'b10100, 5'b0, 1'b0);
    check_val("b_second", m_valid, 5'b10000);
    check_val("b_second_data", m_data, 8'hB1);
    cyc(1'b0, 8'h00, 5'b11111, 5'b0, 1'b0);
    check_val("b_wrap", m_valid, 5'b00001);
    cyc(1'b0, 8'h00, 5'b0, 5'b10101, 1'b0);
    cyc(1'b0, 8'h00, 5'b0, 5'b0, 1'b0);
    check_val("b_clear_busy", busy, 1'b0);

    // Credit limit on child 1: three go out, the fourth waits for a done.
    cyc(1'b1, 8'hC0, 5'b00010, 5'b0, 1'b0);
    for (int k = 1; k < 4; k++) begin
      cyc(1'b1, 8'hC0 + 8'(k), 5'b00010, 5'b0, 1'b0);
      check_val("c_disp", m_valid, 5'b00010);
    end
    cyc(1'b0, 8'h00, 5'b00010, 5'b0, 1'b0);
    check_val("c_full_m_valid", m_valid, 5'b0);
    check_val("c_full_s_ready", s_ready, 1'b0);
    check_val("c_full_data", m_data, 8'hC3);
    cyc(1'b0, 8'h00, 5'b00010, 5'b00010, 1'b0);
    check_val("c_done_cycle", m_valid, 5'b0);
    cyc(1'b0, 8'h00, 5'b00010, 5'b0, 1'b0);
    check_val("c_fourth", m_valid, 5'b00010);
    check_val("c_fourth_data", m_data, 8'hC3);
    repeat (3) cyc(1'b0, 8'h00, 5'b0, 5'b00010, 1'b0);
    cyc(1'b0, 8'h00, 5'b0, 5'b0, 1'b0);
    check_val("c_clear_busy", busy, 1'b0);
    check_val("c_clear_err", err_underflow, 1'b0);

    // Dispatch and done to child 2 in the same cycle leave its count at 1.
    cyc(1'b1, 8'hD0, 5'b00100, 5'b0, 1'b0);
    cyc(1'b1, 8'hD1, 5'b00100, 5'b0, 1'b0);
    check_val("d_first", m_valid, 5'b00100);
    cyc(1'b0, 8'h00, 5'b00100, 5'b00100, 1'b0);
    check_val("d_same_cycle", m_valid, 5'b00100);
    cyc(1'b0, 8'h00, 5'b0, 5'b0, 1'b0);
    check_val("d_err", err_underflow, 1'b0);
    check_val("d_busy", busy, 1'b1);
    cyc(1'b0, 8'h00, 5'b0, 5'b00100, 1'b0);
    cyc(1'b0, 8'h00, 5'b0, 5'b0, 1'b0);
    check_val("d_final_busy", busy, 1'b0);
    check_val("d_final_err", err_underflow, 1'b0);

    // Flush with two outstanding (children 3 and 4).
    cyc(1'b1, 8'hE0, 5'b11111, 5'b0, 1'b0);
    cyc(1'b1, 8'hE1, 5'b11111, 5'b0, 1'b0);
    check_val("f_disp3", m_valid, 5'b01000);
    cyc(1'b0, 8'h00, 5'b11111, 5'b0, 1'b0);
    check_val("f_disp4", m_valid, 5'b10000);
    cyc(1'b0, 8'h00, 5'b11111, 5'b0, 1'b1);
    cyc(1'b1, 8'hFF, 5'b11111, 5'b0, 1'b1);
    check_val("f_s_ready", s_ready, 1'b0);
    check_val("f_busy", busy, 1'b1);
    check_val("f_fd_early", flush_done, 1'b0);
    cyc(1'b0, 8'h00, 5'b11111, 5'b01000, 1'b1);
    check_val("f_no_accept", m_valid, 5'b0);
    check_val("f_fd_mid", flush_done, 1'b0);
    cyc(1'b0, 8'h00, 5'b11111, 5'b10000, 1'b1);
    check_val("f_fd_last_done", flush_done, 1'b0);
    cyc(1'b0, 8'h00, 5'b11111, 5'b0, 1'b1);
    check_val("f_fd_pulse", flush_done, 1'b1);
    check_val("f_busy_off", busy, 1'b0);
    cyc(1'b0, 8'h00, 5'b11111, 5'b0, 1'b1);
    check_val("f_fd_once", flush_done, 1'b0);
    check_val("f_idle_ready", s_ready, 1'b0);
    cyc(1'b0, 8'h00, 5'b11111, 5'b0, 1'b0);
    check_val("f_held_idle", s_ready, 1'b0);
    cyc(1'b0, 8'h00, 5'b11111, 5'b0, 1'b0);
    check_val("f_run_again", s_ready, 1'b1);

    // Underflow on child 3 is sticky.
    cyc(1'b0, 8'h00, 5'b0, 5'b01000, 1'b0);
    check_val("e_err_before", err_underflow, 1'b0);
    cyc(1'b0, 8'h00, 5'b0, 5'b0, 1'b0);
    check_val("e_err_set", err_underflow, 1'b1);
    check_val("e_busy", busy, 1'b0);
    repeat (3) cyc(1'b0, 8'h00, 5'b0, 5'b0, 1'b0);
    check_val("e_err_sticky", err_underflow, 1'b1);

    // Reset with an item held, then a done right after release.
    cyc(1'b1, 8'h77, 5'b0, 5'b0, 1'b0);
    cyc(1'b0, 8'h00, 5'b0, 5'b0, 1'b0);
    check_val("r_busy_held", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_val("r_busy", busy, 1'b0);
    check_val("r_err", err_underflow, 1'b0);
    check_val("r_s_ready", s_ready, 1'b0);
    check_val("r_flush_done", flush_done, 1'b0);
    cyc(1'b0, 8'h00, 5'b0, 5'b0, 1'b0);
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, 5'b0, 5'b00001, 1'b0);
    cyc(1'b1, 8'h5A, 5'b0, 5'b0, 1'b1);
    check_val("r_underflow", err_underflow, 1'b1);
    check_val("g_accept_ready", s_ready, 1'b1);
    cyc(1'b0, 8'h00, 5'b0, 5'b0, 1'b0);
    check_val("g_drain_ready", s_ready, 1'b0);
    check_val("g_held_data", m_data, 8'h5A);
    check_val("g_busy", busy, 1'b1);
    cyc(1'b0, 8'h00, 5'b11111, 5'b0, 1'b0);
    check_val("g_drain_disp", m_valid, 5'b00001);
    cyc(1'b0, 8'h00, 5'b0, 5'b00001, 1'b0);
    check_val("g_fd_wait", flush_done, 1'b0);
    cyc(1'b0, 8'h00, 5'b0, 5'b0, 1'b0);
    check_val("g_fd_pulse", flush_done, 1'b1);
    cyc(1'b0, 8'h00, 5'b0, 5'b0, 1'b0);
    check_val("g_idle", s_ready, 1'b0);
    check_val("g_fd_off", flush_done, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/subgroup_dispatcher.md
SUBGROUP_DISPATCHER -- requirements
Module: subgroup_dispatcher

Interface
REQ-001 SHALL have parameter NUM_CHILD, default 5: number of child instances fed.
REQ-002 SHALL have parameter DATA_W, default 8: payload width.
REQ-003 SHALL have parameter MAX_OUT, default 3: maximum outstanding items per child, range 1..15.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port s_valid, input, 1 bit: upstream item valid.
REQ-007 SHALL have port s_ready, output, 1 bit: item accepted when s_valid && s_ready.
REQ-008 SHALL have port s_data, input, DATA_W bits: upstream payload.
REQ-009 SHALL have port m_valid, output, NUM_CHILD bits: per-child valid, at most one bit set.
REQ-010 SHALL have port m_ready, input, NUM_CHILD bits: per-child ready.
REQ-011 SHALL have port m_data, output, DATA_W bits: payload broadcast to all children.
REQ-012 SHALL have port done, input, NUM_CHILD bits: per-child one-cycle completion pulse.
REQ-013 SHALL have port flush, input, 1 bit: request to drain and stop.
REQ-014 SHALL have port flush_done, output, 1 bit: one-cycle pulse when drain completes.
REQ-015 SHALL have port busy, output, 1 bit: high when holding register full or any outstanding count nonzero.
REQ-016 SHALL have port err_underflow, output, 1 bit: sticky, set by done to a child whose count is 0.

Function
REQ-017 SHALL hold one accepted item in a holding register; s_ready = (state==RUN) && (!hold_valid || dispatch_now).
REQ-018 SHALL keep m_data equal to the holding register; latency s_data accepted to m_data presented is 1 cycle.
REQ-019 SHALL consider child i eligible when hold_valid && m_ready[i] && cnt[i] < MAX_OUT.
REQ-020 SHALL assert m_valid[i] combinationally for the first eligible child searching rr_ptr, rr_ptr+1, ... modulo NUM_CHILD; dispatch_now = |m_valid.
REQ-021 SHALL on dispatch to child k set rr_ptr to k+1, wrapping NUM_CHILD-1 -> 0; rr_ptr unchanged otherwise.
REQ-022 SHALL update cnt[i]: +1 on dispatch to i, -1 on done[i], unchanged when both occur in the same cycle.
REQ-023 SHALL on done[i] with cnt[i]==0 (and no same-cycle dispatch to i) leave cnt[i] at 0 and set err_underflow.
REQ-024 SHALL implement FSM IDLE, RUN, DRAIN: IDLE->RUN when !flush; RUN->DRAIN on flush; DRAIN->IDLE when !hold_valid and all cnt==0, pulsing flush_done on that transition.
REQ-025 SHALL keep dispatching a held item in DRAIN but accept no new items (s_ready=0 in IDLE and DRAIN).
REQ-026 SHALL give a flush arriving in the same cycle as an upstream handshake precedence: the item is accepted, the state moves to DRAIN.
REQ-027 SHALL leave IDLE only when flush is low, so a held-high flush keeps the block in IDLE.

Reset
REQ-028 SHALL on rst_n low immediately clear: state=IDLE, hold_valid=0, rr_ptr=0, all cnt=0, err_underflow=0, flush_done=0; hence s_ready=0, m_valid=0, busy=0.
REQ-029 SHALL on reset mid-operation discard the held item and outstanding counts without emitting flush_done; done pulses in the first cycle after release are counted as underflow.

Structure
REQ-030 SHALL place the FSM state enum (IDLE, RUN, DRAIN) and the MAX_OUT counter width constant in a shared package subgroup_pkg.
REQ-031 SHALL implement the per-child outstanding counter as sub-module subgroup_credit_cnt, instantiated NUM_CHILD times; the round-robin search stays in the top.

Verification
REQ-032 SHALL cover: reset release, flush=0, 5 items back-to-back, all m_ready=1, no done -> dispatched to children 0,1,2,3,4 in order, rr_ptr=0 afterwards.
REQ-033 SHALL cover: m_ready=5'b10100, rr_ptr=0, one item -> m_valid=5'b00100, rr_ptr=3; next item -> m_valid=5'b10000, rr_ptr wraps to 0.
REQ-034 SHALL cover: MAX_OUT=3, only child 1 ready, 4 items, no done -> 3 dispatched, s_ready low with item held; one done[1] pulse -> 4th dispatched the following cycle.
REQ-035 SHALL cover: dispatch to child 2 and done[2] in the same cycle with cnt[2]=1 -> cnt[2] stays 1, err_underflow stays 0.
REQ-036 SHALL cover: done[3] with cnt[3]=0 -> err_underflow=1 and remains 1 until reset.
REQ-037 SHALL cover: flush with 2 outstanding items -> s_ready=0 at once, busy=1, flush_done pulses once exactly one cycle after the last done, state IDLE.
